// File: rtl/ls_mezz_uart_rx_fifo.sv
// ls_mezz_uart_rx_fifo
// UART receiver for the mezzanine rx pin: 16x oversampled frames into a
// first-word-fall-through byte FIFO with a valid/ready output stream and an
// active-low RTS flow-control output.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity checking;
// without it frames are 8N1 and parity_err is tied low.
module ls_mezz_uart_rx_fifo #(
  parameter int CLK_DIV       = 54,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          rtsn,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] RTS_L   = LW'(RTS_THRESHOLD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    sc;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          armed;
  logic          start_enter;
  logic          stop_sample;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          pop;
  logic          push_ok;

`ifdef UART_RX_PARITY_EN
  logic          parity_bad;
  logic          parity_err_r;
`endif

  // Two-flop synchronizer; the line idles high so the flops reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  assign tick        = (div_cnt == DIV_MAX);
  assign start_enter = (state == IDLE) && tick && armed && !rxs;
  assign stop_sample = (state == STOP) && tick && (sc == 4'd15);

`ifdef UART_RX_PARITY_EN
  assign push = stop_sample && rxs && !parity_bad;
`else
  assign push = stop_sample && rxs;
`endif

  // Oversample tick divider; restarted on start-bit detection to lock phase.
  always_ff @(posedge clk) begin
    if (rst || start_enter || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Frame FSM: start qualification, data shift, optional parity, stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sc        <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      armed     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE: begin
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
              sc    <= 4'd0;
            end
          end
          START: begin
            if (sc == 4'd7) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                sc      <= 4'd0;
                bit_idx <= 3'd0;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
          DATA: begin
            if (sc == 4'd15) begin
              shift <= {rxs, shift[7:1]};
              sc    <= 4'd0;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
          PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (sc == 4'd15) begin
              parity_bad   <= ^{rxs, shift};
              parity_err_r <= ^{rxs, shift};
              sc           <= 4'd0;
              state        <= STOP;
            end else begin
              sc <= sc + 4'd1;
            end
`else
            state <= IDLE;
`endif
          end
          STOP: begin
            if (sc == 4'd15) begin
              if (!rxs) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
              state <= IDLE;
              sc    <= 4'd0;
`ifdef UART_RX_PARITY_EN
              parity_bad <= 1'b0;
`endif
            end else begin
              sc <= sc + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign pop     = m_valid && m_ready;
  assign push_ok = push && ((level != DEPTH_L) || pop);

  // Next FIFO occupancy; a push into a full FIFO only lands alongside a pop.
  always_comb begin
    level_next = level;
    if (push_ok && !pop) begin
      level_next = level + LW'(1);
    end else if (!push_ok && pop) begin
      level_next = level - LW'(1);
    end
  end

  // Byte storage, left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers, occupancy and the overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level   <= level_next;
      overrun <= push && !push_ok;
    end
  end

  // RTS follows the occupancy the FIFO is about to have.
  always_ff @(posedge clk) begin
    if (rst) begin
      rtsn <= 1'b1;
    end else begin
      rtsn <= (level_next >= RTS_L);
    end
  end

  assign m_valid    = (level != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level = level;

endmodule

// File: tb/tb_ls_mezz_uart_rx_fifo.sv
// tb_ls_mezz_uart_rx_fifo
// Directed bench for ls_mezz_uart_rx_fifo with CLK_DIV=4 (64 clk per bit).
// Expected bytes go into a scoreboard queue when a frame is issued; a
// negedge monitor pops and compares on every accepted handshake.
module tb_ls_mezz_uart_rx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int THR     = 12;
  localparam int BIT_CLK = CLK_DIV * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       m_ready = 1'b0;
  logic       rtsn;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] fifo_level;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq[$];
  int         pop_cnt = 0;
  int         frame_cnt = 0;
  int         ovr_cnt = 0;
  int         par_cnt = 0;
  int         par_total = 0;
  int         valid_cycles = 0;
  int         max_level = 0;
  logic       rts_high_seen = 1'b0;
  logic [1:0] phase = 2'd0;
  int         lat = 0;

  ls_mezz_uart_rx_fifo #(
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(DEPTH),
    .RTS_THRESHOLD(THR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .rtsn(rtsn),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_level(fifo_level),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) phase <= phase + 2'd1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compares every accepted byte and counts pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) frame_cnt++;
      if (overrun) ovr_cnt++;
      if (parity_err) begin
        par_cnt++;
        par_total++;
      end
      if (m_valid) valid_cycles++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (rtsn) rts_high_seen = 1'b1;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got %0h expected none", m_data);
        end else begin
          checkOutput("pop_data", {24'h0, m_data}, {24'h0, expq.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alignPhase();
    do begin
      @(posedge clk);
      #1;
    end while (phase != 2'd0);
  endtask

  task automatic clearStats();
    pop_cnt = 0;
    frame_cnt = 0;
    ovr_cnt = 0;
    par_cnt = 0;
    valid_cycles = 0;
    max_level = 0;
    rts_high_seen = 1'b0;
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic sendFrame(input logic [7:0] d, input logic stop_b, input logic par_b);
    uart_rx = 1'b0;
    waitCycles(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      waitCycles(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par_b;
    waitCycles(BIT_CLK);
`endif
    uart_rx = stop_b;
    waitCycles(BIT_CLK);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic expect_push);
    alignPhase();
    if (expect_push) expq.push_back(d);
    sendFrame(d, 1'b1, ^d);
    uart_rx = 1'b1;
    waitCycles(8);
  endtask

  initial begin
    // Reset state
    waitCycles(4);
    checkOutput("rst_m_valid", {31'h0, m_valid}, 0);
    checkOutput("rst_level", {27'h0, fifo_level}, 0);
    checkOutput("rst_rtsn", {31'h0, rtsn}, 1);
    checkOutput("rst_m_data", {24'h0, m_data}, 0);
    checkOutput("rst_pulses", {29'h0, frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    waitCycles(20);
    checkOutput("rtsn_after_rst", {31'h0, rtsn}, 0);

    // Single byte with consumer ready; latency to m_valid is recorded
    m_ready = 1'b1;
    clearStats();
    alignPhase();
    expq.push_back(8'hA5);
    lat = -1;
    fork
      sendFrame(8'hA5, 1'b1, ^8'hA5);
      begin
        for (int k = 1; k < 2000; k++) begin
          @(posedge clk);
          #1;
          if (m_valid) begin
            lat = k;
            break;
          end
        end
      end
    join
    uart_rx = 1'b1;
    waitCycles(8);
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL a5_timeout: got no m_valid expected m_valid within 2000 cycles");
      lat = 600;
    end
    checkOutput("a5_pops", pop_cnt, 1);
    checkOutput("a5_valid_cycles", valid_cycles, 1);
    checkOutput("a5_peak_level", max_level, 1);
    checkOutput("a5_rts_high", {31'h0, rts_high_seen}, 0);
    checkOutput("a5_queue_empty", expq.size(), 0);

    // Short low glitch is rejected
    clearStats();
    alignPhase();
    uart_rx = 1'b0;
    waitCycles(12);
    uart_rx = 1'b1;
    waitCycles(2 * BIT_CLK);
    checkOutput("glitch_pops", pop_cnt, 0);
    checkOutput("glitch_errs", frame_cnt + ovr_cnt + par_cnt, 0);
    checkOutput("glitch_level", {27'h0, fifo_level}, 0);

    // Framing error, then a held break, then recovery
    clearStats();
    alignPhase();
    sendFrame(8'h3C, 1'b0, ^8'h3C);
    checkOutput("ferr_count", frame_cnt, 1);
    checkOutput("ferr_pops", pop_cnt, 0);
    waitCycles(20 * BIT_CLK);
    checkOutput("break_ferr_count", frame_cnt, 1);
    checkOutput("break_level", {27'h0, fifo_level}, 0);
    uart_rx = 1'b1;
    waitCycles(2 * BIT_CLK);
    applyStimulus(8'h55, 1'b1);
    checkOutput("recover_pops", pop_cnt, 1);
    checkOutput("recover_queue_empty", expq.size(), 0);

    // Fill with consumer stalled: RTS threshold, full, overrun
    m_ready = 1'b0;
    clearStats();
    for (int i = 0; i < 11; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
    checkOutput("fill11_level", {27'h0, fifo_level}, 11);
    checkOutput("fill11_rtsn", {31'h0, rtsn}, 0);
    applyStimulus(8'h1B, 1'b1);
    checkOutput("fill12_level", {27'h0, fifo_level}, 12);
    checkOutput("fill12_rtsn", {31'h0, rtsn}, 1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h20 + 8'(i), 1'b1);
    checkOutput("fill16_level", {27'h0, fifo_level}, 16);
    applyStimulus(8'hEE, 1'b0);
    checkOutput("ovr_count", ovr_cnt, 1);
    checkOutput("ovr_level", {27'h0, fifo_level}, 16);
    checkOutput("fill_pops", pop_cnt, 0);

    // Pop five one at a time; RTS releases at level 11
    for (int k = 1; k <= 5; k++) begin
      m_ready = 1'b1;
      waitCycles(1);
      m_ready = 1'b0;
      if (k == 4) begin
        checkOutput("pop4_level", {27'h0, fifo_level}, 12);
        checkOutput("pop4_rtsn", {31'h0, rtsn}, 1);
      end
      if (k == 5) begin
        checkOutput("pop5_level", {27'h0, fifo_level}, 11);
        checkOutput("pop5_rtsn", {31'h0, rtsn}, 0);
      end
    end

    // Refill to full, then push and pop in the same cycle
    for (int i = 0; i < 5; i++) applyStimulus(8'h30 + 8'(i), 1'b1);
    checkOutput("refill_level", {27'h0, fifo_level}, 16);
    pop_cnt = 0;
    ovr_cnt = 0;
    alignPhase();
    expq.push_back(8'h77);
    fork
      sendFrame(8'h77, 1'b1, ^8'h77);
      begin
        repeat (lat - 1) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
      end
    join
    uart_rx = 1'b1;
    waitCycles(8);
    checkOutput("simul_level", {27'h0, fifo_level}, 16);
    checkOutput("simul_overrun", ovr_cnt, 0);
    checkOutput("simul_pops", pop_cnt, 1);

    // Drain everything and check order via the scoreboard
    m_ready = 1'b1;
    waitCycles(40);
    checkOutput("drain_queue_empty", expq.size(), 0);
    checkOutput("drain_level", {27'h0, fifo_level}, 0);
    checkOutput("drain_rtsn", {31'h0, rtsn}, 0);

    // Reset in the middle of DATA discards the FIFO and the partial byte
    m_ready = 1'b0;
    applyStimulus(8'h61, 1'b1);
    applyStimulus(8'h62, 1'b1);
    checkOutput("pre_rst_level", {27'h0, fifo_level}, 2);
    alignPhase();
    uart_rx = 1'b0;
    waitCycles(BIT_CLK);
    uart_rx = 1'b1;
    waitCycles(BIT_CLK);
    uart_rx = 1'b0;
    waitCycles(BIT_CLK + 20);
    rst = 1'b1;
    waitCycles(2);
    checkOutput("midrst_level", {27'h0, fifo_level}, 0);
    checkOutput("midrst_m_valid", {31'h0, m_valid}, 0);
    checkOutput("midrst_rtsn", {31'h0, rtsn}, 1);
    expq.delete();
    uart_rx = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2 * BIT_CLK);
    clearStats();
    m_ready = 1'b1;
    applyStimulus(8'h5A, 1'b1);
    checkOutput("post_rst_pops", pop_cnt, 1);
    checkOutput("post_rst_ferr", frame_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Parity: good parity accepted, bad parity dropped with a pulse
    clearStats();
    alignPhase();
    expq.push_back(8'h01);
    sendFrame(8'h01, 1'b1, 1'b1);
    uart_rx = 1'b1;
    waitCycles(8);
    checkOutput("par_good_pops", pop_cnt, 1);
    checkOutput("par_good_err", par_cnt, 0);
    alignPhase();
    sendFrame(8'h01, 1'b1, 1'b0);
    uart_rx = 1'b1;
    waitCycles(8);
    checkOutput("par_bad_err", par_cnt, 1);
    checkOutput("par_bad_pops", pop_cnt, 1);
    checkOutput("par_bad_ferr", frame_cnt, 0);
`else
    checkOutput("parity_never", par_total, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
